// File: rtl/sintable_pkg.sv
// Shared types and constants for the quarter-wave sine sequencer.
// Holds FSM encoding, default widths and quadrant helpers.
package sintable_pkg;

   localparam int PW_DEF = 24;
   localparam int AW_DEF = 8;
   localparam int DW_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   localparam logic [1:0] QUAD_0 = 2'd0;
   localparam logic [1:0] QUAD_1 = 2'd1;
   localparam logic [1:0] QUAD_2 = 2'd2;
   localparam logic [1:0] QUAD_3 = 2'd3;

   // Falling quarters read the table backwards.
   function automatic logic quad_mirrors(input logic [1:0] q);
      return (q == QUAD_1) || (q == QUAD_3);
   endfunction

   // Lower half of the wave is negative.
   function automatic logic quad_negates(input logic [1:0] q);
      return (q == QUAD_2) || (q == QUAD_3);
   endfunction

endpackage

// File: rtl/sintable_if.sv
// Table read bus plus the signed sample valid/ready stream.
// master = sequencer side, slave = table/sink side.
interface sintable_if
   import sintable_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);

   logic [AW-1:0] o_tbl_addr;
   logic          o_tbl_rd;
   logic [DW-2:0] i_tbl_data;
   logic [DW-1:0] o_sample;
   logic          o_valid;
   logic          i_ready;

   modport master (
      output o_tbl_addr,
      output o_tbl_rd,
      output o_sample,
      output o_valid,
      input  i_tbl_data,
      input  i_ready
   );

   modport slave (
      input  o_tbl_addr,
      input  o_tbl_rd,
      input  o_sample,
      input  o_valid,
      output i_tbl_data,
      output i_ready
   );

endinterface

// File: rtl/sintable_fold.sv
// Folds a phase index and quadrant into a quarter-wave address.
// Also reports whether the looked-up magnitude must be negated.
module sintable_fold
   import sintable_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic [AW-1:0] idx,
   input  logic [1:0]    quad,
   output logic [AW-1:0] addr,
   output logic          neg
);

   assign addr = quad_mirrors(quad) ? ~idx : idx;
   assign neg  = quad_negates(quad);

endmodule

// File: rtl/sintable_seq.sv
// Phase-accumulator NCO sequencer around an external quarter-wave ROM.
// One lookup per sample: ISSUE -> CAPTURE -> HOLD until accepted.
module sintable_seq
   import sintable_pkg::*;
#(
   parameter int PW = PW_DEF,
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_en,
   input  logic [PW-1:0] i_phase_inc,
   input  logic          i_inc_load,
   input  logic          i_phase_clr,
   sintable_if.master    bus
);

   state_t        state;
   state_t        state_nx;
   logic [PW-1:0] acc;
   logic [PW-1:0] inc;
   logic [1:0]    q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] sample_q;

   logic [1:0]    quad_sel;
   logic [AW-1:0] f_addr;
   logic          f_neg;
   logic [DW-1:0] mag_ext;
   logic [DW-1:0] sample_nx;

   // Fold sees the live quadrant in ISSUE, the latched one afterwards.
   assign quad_sel = (state == S_ISSUE) ? acc[PW-1 -: 2] : q;

   sintable_fold #(
      .AW (AW)
   ) u_fold (
      .idx  (acc[PW-3 -: AW]),
      .quad (quad_sel),
      .addr (f_addr),
      .neg  (f_neg)
   );

   assign mag_ext   = {1'b0, bus.i_tbl_data};
   assign sample_nx = f_neg ? (~mag_ext + 1'b1) : mag_ext;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      bus.o_tbl_rd   = 1'b0;
      bus.o_tbl_addr = addr_q;
      bus.o_valid    = 1'b0;
      bus.o_sample   = sample_q;
      unique case (state)
         S_IDLE: begin
            if (i_en) state_nx = S_ISSUE;
         end
         S_ISSUE: begin
            bus.o_tbl_rd   = 1'b1;
            bus.o_tbl_addr = f_addr;
            state_nx       = S_CAPTURE;
         end
         S_CAPTURE: begin
            state_nx = S_HOLD;
         end
         S_HOLD: begin
            bus.o_valid = 1'b1;
            if (bus.i_ready) begin
               state_nx = i_en ? S_ISSUE : S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc      <= '0;
         inc      <= '0;
         q        <= '0;
         addr_q   <= '0;
         sample_q <= '0;
      end else begin
         if (i_inc_load) inc <= i_phase_inc;
         // Clear wins over the per-lookup advance.
         if (i_phase_clr) begin
            acc <= '0;
         end else if (state == S_ISSUE) begin
            acc <= acc + inc;
         end
         if (state == S_ISSUE) begin
            q      <= acc[PW-1 -: 2];
            addr_q <= f_addr;
         end
         if (state == S_CAPTURE) begin
            sample_q <= sample_nx;
         end
      end
   end

endmodule

// File: tb/tb_sintable_seq.sv
// Directed + randomized bench for sintable_seq against an
// arithmetic phase/quadrant model and a registered table model.
module tb_sintable_seq;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_en;
   logic [23:0] i_phase_inc;
   logic        i_inc_load;
   logic        i_phase_clr;

   sintable_if #(.AW(8), .DW(8)) bus ();

   sintable_seq #(
      .PW (24),
      .AW (8),
      .DW (8)
   ) dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_en        (i_en),
      .i_phase_inc (i_phase_inc),
      .i_inc_load  (i_inc_load),
      .i_phase_clr (i_phase_clr),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Registered ROM: mag = addr[7:1], one cycle after the strobe.
   always @(posedge clk) begin
      if (bus.o_tbl_rd) bus.i_tbl_data <= bus.o_tbl_addr[7:1];
   end

   int errors = 0;
   int checks = 0;
   logic [23:0] m_acc;
   logic [23:0] m_inc;
   int last_rd = 0;
   int gap_exp = -1;
   int valid_cyc = 0;
   logic [7:0] addrs[$];

   function automatic logic [7:0] exp_addr(input logic [23:0] a);
      int unsigned quad;
      int unsigned idx;
      quad = a / (1 << 22);
      idx  = (a / (1 << 14)) % 256;
      return 8'((quad % 2 == 1) ? 255 - idx : idx);
   endfunction

   function automatic logic [7:0] exp_samp(input logic [23:0] a);
      int mag;
      int s;
      mag = int'(exp_addr(a)) / 2;
      s   = ((a / (1 << 22)) >= 2) ? -mag : mag;
      return 8'(s);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // One full lookup, entered at a negedge in IDLE(en=1) or ISSUE.
   task automatic lookup(input int stall, input bit do_clr,
                         input bit do_load, input logic [23:0] ld,
                         input bit drop_en);
      logic [7:0] es;
      logic [7:0] ea;
      int n;
      n = 0;
      while (bus.o_tbl_rd !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("rd_seen", 32'(bus.o_tbl_rd), 1);
      ea = exp_addr(m_acc);
      chk("addr", 32'(bus.o_tbl_addr), 32'(ea));
      addrs.push_back(bus.o_tbl_addr);
      if (gap_exp >= 0) chk("rd_gap", cyc - last_rd, gap_exp);
      last_rd = cyc;
      es = exp_samp(m_acc);
      m_acc = do_clr ? 24'h0 : m_acc + m_inc;
      if (do_clr) i_phase_clr = 1'b1;
      @(negedge clk);
      i_phase_clr = 1'b0;
      chk("addr_hold", 32'(bus.o_tbl_addr), 32'(ea));
      if (do_load) begin
         i_phase_inc = ld;
         i_inc_load  = 1'b1;
         m_inc       = ld;
      end
      if (stall > 0) bus.i_ready = 1'b0;
      if (drop_en) i_en = 1'b0;
      @(negedge clk);
      i_inc_load = 1'b0;
      valid_cyc = cyc;
      chk("valid", 32'(bus.o_valid), 1);
      chk("sample", 32'(bus.o_sample), 32'(es));
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         chk("bp_valid", 32'(bus.o_valid), 1);
         chk("bp_sample", 32'(bus.o_sample), 32'(es));
         chk("bp_rd", 32'(bus.o_tbl_rd), 0);
      end
      bus.i_ready = 1'b1;
      @(negedge clk);
      gap_exp = drop_en ? -1 : 3 + stall;
   endtask

   initial begin
      int rd_cnt;
      int c0;
      i_reset     = 1'b1;
      i_en        = 1'b0;
      i_phase_inc = '0;
      i_inc_load  = 1'b0;
      i_phase_clr = 1'b0;
      bus.i_ready = 1'b1;
      m_acc = '0;
      m_inc = '0;

      // Reset behaviour
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(bus.o_valid), 0);
      chk("rst_rd", 32'(bus.o_tbl_rd), 0);
      i_reset = 1'b0;
      rd_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.o_tbl_rd !== 1'b0) rd_cnt++;
      end
      chk("idle_rd_cnt", rd_cnt, 0);
      chk("idle_valid", 32'(bus.o_valid), 0);
      chk("idle_sample", 32'(bus.o_sample), 0);
      chk("idle_addr", 32'(bus.o_tbl_addr), 0);

      // Steady stream, inc = 0x004000
      i_phase_inc = 24'h004000;
      i_inc_load  = 1'b1;
      m_inc       = 24'h004000;
      @(negedge clk);
      i_inc_load = 1'b0;
      c0 = cyc;
      i_en = 1'b1;
      lookup(0, 0, 0, 0, 0);
      chk("first_valid_lat", valid_cyc - c0, 3);
      repeat (3) lookup(0, 0, 0, 0, 0);
      chk("stream_addr3", 32'(addrs[3]), 3);

      // Drop enable mid-lookup: sample completes, then idle
      lookup(0, 0, 0, 0, 1);
      rd_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         if (bus.o_tbl_rd !== 1'b0 || bus.o_valid !== 1'b0) rd_cnt++;
         @(negedge clk);
      end
      chk("drop_en_idle", rd_cnt, 0);

      // Quadrant fold, inc = 0x400000 from phase 0
      i_phase_clr = 1'b1;
      i_phase_inc = 24'h400000;
      i_inc_load  = 1'b1;
      m_acc = '0;
      m_inc = 24'h400000;
      @(negedge clk);
      i_phase_clr = 1'b0;
      i_inc_load  = 1'b0;
      i_en = 1'b1;
      repeat (6) lookup(0, 0, 0, 0, 0);

      // Backpressure for 10 cycles, then immediate ISSUE
      lookup(10, 0, 0, 0, 0);
      chk("bp_issue_next", 32'(bus.o_tbl_rd), 1);

      // Clear during ISSUE (with reload), then increment change
      lookup(0, 1, 1, 24'h004000, 0);
      lookup(0, 0, 0, 0, 0);
      chk("clr_addr0", 32'(addrs[$]), 0);
      lookup(0, 0, 1, 24'h008000, 0);
      lookup(0, 0, 0, 0, 0);
      lookup(0, 0, 0, 0, 0);
      chk("inc_step2", 32'(addrs[$] - addrs[$-1]), 2);

      // Randomized run against the model
      for (int it = 0; it < 24; it++) begin
         lookup($urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                $urandom_range(0, 1) == 1, 24'($urandom), 0);
      end

      // Reset mid-lookup (during CAPTURE)
      while (bus.o_tbl_rd !== 1'b1 && cyc < 90000) @(negedge clk);
      @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      chk("midrst_valid", 32'(bus.o_valid), 0);
      chk("midrst_rd", 32'(bus.o_tbl_rd), 0);
      chk("midrst_sample", 32'(bus.o_sample), 0);
      i_reset = 1'b0;
      m_acc = '0;
      m_inc = '0;
      gap_exp = -1;
      lookup(0, 0, 0, 0, 0);
      chk("midrst_addr0", 32'(addrs[$]), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sintable_seq.md
# sintable_seq

Sequencer that drives the quarter-wave sine lookup table as a numerically controlled oscillator. It keeps a phase accumulator, folds the phase into a quarter-wave table address, and issues one table read per sample. It restores the sign from the quadrant and presents signed samples on a valid/ready stream. It sits between the control registers (frequency word, enable) and the downstream filter chain; the table itself is an external registered ROM with one cycle of read latency.

## Interface
- PW, 24: phase accumulator width.
- AW, 8: quarter-wave table address width.
- DW, 8: signed output sample width; table magnitude is DW-1 bits.
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_en  in  1  run enable; sampled in IDLE and in HOLD.
- i_phase_inc  in  PW  phase increment (frequency word).
- i_inc_load  in  1  one-cycle pulse; latches i_phase_inc.
- i_phase_clr  in  1  one-cycle pulse; zeroes the accumulator.
- o_tbl_addr  out  AW  table address.
- o_tbl_rd  out  1  table read strobe, one cycle per lookup.
- i_tbl_data  in  DW-1  table magnitude, valid the cycle after o_tbl_rd.
- o_sample  out  DW  signed two's-complement sample.
- o_valid  out  1  sample valid.
- i_ready  in  1  downstream accept.

## Operation
- Registers:
  - acc[PW-1:0]: phase accumulator.
  - inc[PW-1:0]: active increment.
  - q[1:0]: latched quadrant.
  - state.
- Phase split for each lookup:
  - quadrant = acc[PW-1:PW-2].
  - idx = acc[PW-3:PW-2-AW].
- Address fold: quadrants 0 and 2 use addr = idx; quadrants 1 and 3 use addr = ~idx.
- Sign: quadrants 0 and 1 give o_sample = {1'b0, mag}; quadrants 2 and 3 give o_sample = -{1'b0, mag}, two's complement. A magnitude of 0 yields 0.
- FSM states:
  - IDLE: if i_en, go to ISSUE.
  - ISSUE: o_tbl_rd=1 and o_tbl_addr = fold(acc). Latch q. acc <= acc + inc, wrapping mod 2^PW. Go to CAPTURE.
  - CAPTURE: register the signed sample from i_tbl_data and q. Go to HOLD.
  - HOLD: o_valid=1. On i_ready: if i_en go to ISSUE, else go to IDLE. Without i_ready, stay in HOLD.
- i_inc_load: inc <= i_phase_inc in any state. The new value first applies at the next ISSUE.
- i_phase_clr: acc <= 0 in any state, and takes precedence over the ISSUE advance. An in-flight sample keeps its latched q and address.
- Dropping i_en mid-lookup does not abort: the current sample completes through HOLD and its handshake, then the FSM returns to IDLE.

## Timing
- Reset values:
  - state = IDLE; acc = 0; inc = 0; q = 0.
  - o_tbl_addr = 0; o_tbl_rd = 0.
  - o_sample = 0; o_valid = 0.
- Reset mid-operation takes effect on the next edge and discards any in-flight sample. o_valid is low in the following cycle.
- Latency: with i_en=1 in IDLE at cycle t:
  - ISSUE at t+1.
  - CAPTURE at t+2.
  - o_valid high at t+3.
- Throughput: with i_ready held high, one sample every 3 cycles; o_tbl_rd pulses every 3rd cycle.
- Backpressure: while o_valid=1 and i_ready=0, o_sample is stable, o_tbl_rd=0 and acc is unchanged (unless cleared).
- o_tbl_addr holds its last value outside ISSUE; the table must qualify reads with o_tbl_rd.
- Output handshake: transfer occurs only on a cycle with o_valid && i_ready. o_valid never drops without a transfer, except on reset.

## Structure
- Shared package sintable_pkg holds:
  - state encoding (IDLE, ISSUE, CAPTURE, HOLD).
  - default parameter constants PW, AW, DW.
  - quadrant constants.
- Natural sub-module: sintable_fold, combinational. Inputs: acc slice and quadrant. Outputs: folded address and a negate flag. It is reused by any future cosine or I/Q variant.
- The FSM, accumulator and output register live in sintable_seq.

## Test plan
Common setup: PW=24, AW=8, DW=8; the table model returns mag = addr[7:1].
1. Reset behaviour: i_reset high 3 cycles, then low with i_en=0 for 10 cycles -> all outputs 0, o_tbl_rd never asserted.
2. Steady stream: inc=0x004000, i_en=1, i_ready=1 -> o_tbl_addr 0, 1, 2, 3 on successive ISSUEs. o_tbl_rd every 3rd cycle. First o_valid 3 cycles after i_en. Samples 0x00, 0x00, 0x01, 0x01.
3. Quadrant fold: inc=0x400000 -> addresses 0, 255, 0, 255. Samples 0x00, 0x7F, 0x00, 0x81, then the pattern repeats (acc wraps).
4. Backpressure: i_ready=0 for 10 cycles with o_valid high -> o_sample constant, no o_tbl_rd, acc unchanged. i_ready=1 -> transfer, then ISSUE in the next cycle.
5. Increment load and clear mid-stream:
   - i_inc_load with 0x008000 during CAPTURE -> the next-but-one address steps by 2.
   - i_phase_clr during ISSUE -> the following lookup uses addr 0, and the current sample is unaffected.
6. Reset mid-lookup: assert i_reset during CAPTURE -> no o_valid afterwards. After release with i_en=1, the first address is 0.
